// File: rtl/rs232_tx_arbiter_if.sv
// Bundle of FWFT source-side and transmitter-side signals around rs232_tx_arbiter.
// The master modport is the arbiter's view; the slave modport is the surroundings
// (channel FIFOs and the transmitter).
interface rs232_tx_arbiter_if #(
    parameter int unsigned CHANNELS = 4
);
    localparam int unsigned GW = $clog2(CHANNELS);

    logic [8*CHANNELS-1:0] ch_data;
    logic [CHANNELS-1:0]   ch_empty;
    logic [CHANNELS-1:0]   ch_rden;
    logic [7:0]            tx_data;
    logic                  tx_empty;
    logic                  tx_rden;
    logic [GW-1:0]         grant;
    logic                  busy;

    modport master (
        input  ch_data, ch_empty, tx_rden,
        output ch_rden, tx_data, tx_empty, grant, busy
    );

    modport slave (
        output ch_data, ch_empty, tx_rden,
        input  ch_rden, tx_data, tx_empty, grant, busy
    );
endinterface

// File: rtl/rs232_tx_arbiter.sv
// Packet-fair round-robin arbiter sharing one FWFT byte transmitter among
// CHANNELS FWFT byte sources. A grant lasts up to BURST bytes or until the
// granted channel runs dry; at least one IDLE cycle separates grants.
// Optional macro RS232_TX_ARBITER_TAG_EN: each grant starts with a tag byte
// TAG_BASE | grant before the channel's data.
module rs232_tx_arbiter #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned BURST    = 16,
    parameter logic [7:0]  TAG_BASE = 8'hF0
) (
    input  logic               clock,
    input  logic               resetn,
    rs232_tx_arbiter_if.master bus
);
    localparam int unsigned   GW        = $clog2(CHANNELS);
    localparam int unsigned   CW        = $clog2(BURST + 1);
    localparam logic [CW-1:0] LAST_BYTE = CW'(BURST - 1);
    localparam logic [GW-1:0] LAST_CH   = GW'(CHANNELS - 1);

    generate
        if (CHANNELS < 2 || CHANNELS > 16) begin : g_bad_channels
            $error("rs232_tx_arbiter: CHANNELS must be 2..16");
        end
        if (BURST < 1) begin : g_bad_burst
            $error("rs232_tx_arbiter: BURST must be at least 1");
        end
        if (TAG_BASE[3:0] != 4'h0) begin : g_bad_tag
            $error("rs232_tx_arbiter: TAG_BASE low nibble must be zero");
        end
    endgenerate

`ifdef RS232_TX_ARBITER_TAG_EN
    typedef enum logic [1:0] { IDLE, TAG, STREAM } state_t;
`else
    typedef enum logic [1:0] { IDLE, STREAM } state_t;
`endif

    state_t        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_q,  last_d;
    logic [CW-1:0] count_q, count_d;

    logic          any_req;
    logic [GW-1:0] pick;
    logic [GW-1:0] idx;
    logic          head_empty;
    logic [7:0]    head_data;
    logic          rd_ok;

    assign head_empty = bus.ch_empty[grant_q];
    assign head_data  = bus.ch_data[{grant_q, 3'b000} +: 8];
    assign rd_ok      = bus.tx_rden & ~head_empty;

    // Round-robin pick: first non-empty channel after the last one served.
    always_comb begin
        any_req = 1'b0;
        pick    = '0;
        idx     = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            idx = GW'((32'(last_q) + i + 1) % CHANNELS);
            if (!any_req && !bus.ch_empty[idx]) begin
                any_req = 1'b1;
                pick    = idx;
            end
        end
    end

    // State register; reset drops any grant and restores channel 0 priority.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LAST_CH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

    // Next-state: grant on request, count qualified reads, release on burst end or dry channel.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = pick;
                    count_d = '0;
`ifdef RS232_TX_ARBITER_TAG_EN
                    state_d = TAG;
`else
                    state_d = STREAM;
`endif
                end
            end
`ifdef RS232_TX_ARBITER_TAG_EN
            TAG: begin
                if (bus.tx_rden) begin
                    state_d = STREAM;
                end
            end
`endif
            STREAM: begin
                if (rd_ok) begin
                    count_d = count_q + CW'(1);
                    if (count_q == LAST_BYTE) begin
                        last_d  = grant_q;
                        state_d = IDLE;
                    end
                end else if (head_empty) begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: IDLE is silent, TAG presents the tag, STREAM passes the granted head through.
    always_comb begin
        bus.ch_rden  = '0;
        bus.tx_data  = '0;
        bus.tx_empty = 1'b1;
        case (state_q)
`ifdef RS232_TX_ARBITER_TAG_EN
            TAG: begin
                bus.tx_data  = TAG_BASE | 8'(grant_q);
                bus.tx_empty = 1'b0;
            end
`endif
            STREAM: begin
                bus.tx_data           = head_data;
                bus.tx_empty          = head_empty;
                bus.ch_rden[grant_q]  = rd_ok;
            end
            default: ;
        endcase
    end

    assign bus.grant = grant_q;
    assign bus.busy  = (state_q != IDLE);

endmodule
